bind_stream_mapper: RTL and testbench
=====================================

# bind_stream_mapper

Parametrised memory-side mapper for bind-class kernels. For each word offset of a hypervector, it reads NUM_OPERANDS operand words from the shared single-port DPRAM and streams them to the kernel as one first/last framed burst. It then waits for the kernel result and writes it to the destination hypervector, looping over the whole hypervector length. It sits between the kernel mapper (request side) and one bind/bundle kernel (stream side).

## Interface
- HV_DATA_WIDTH, 32, memory and kernel word width
- HV_ADDRESS_WIDTH, 20, memory address width
- MAX_HYPERVECTOR_LENGTH, 4, maximum words per hypervector; LW = $clog2(MAX_HYPERVECTOR_LENGTH+1)
- NUM_OPERANDS, 2, operands per bind (legal 2..8)

- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- valid  in  1  request strobe from kernel mapper
- hv_base  in  NUM_OPERANDS×HV_ADDRESS_WIDTH  packed operand base addresses; slice 0 is streamed first
- hvc  in  HV_ADDRESS_WIDTH  destination base address
- hv_length  in  LW  words to process
- done  out  1  idle/complete
- error  out  1  one-cycle pulse when a request is rejected
- we_n  out  1  memory write enable, active-low
- address  out  HV_ADDRESS_WIDTH  memory address (registered)
- data_wr  out  HV_DATA_WIDTH  memory write data (registered)
- data_rd  in  HV_DATA_WIDTH  memory read data, valid the cycle after address changes
- k_valid, k_first, k_last  out  1  kernel beat valid, first beat, last beat
- k_data_in  out  HV_DATA_WIDTH  operand word to kernel
- k_data_out  in  HV_DATA_WIDTH  kernel result
- k_ready, k_done  in  1  kernel can accept a beat; kernel result valid

## Operation
- Reset values:
  - done=1, error=0, we_n=1
  - address=all ones, data_wr=0, buff=0
  - k_valid=k_first=k_last=0
  - Counters off=0, op=0
- Request latching: bases, hvc and length are latched on accept. Inputs are ignored afterwards until done=1.
- States:
  - S_IDLE:
    - done=1, we_n=1.
    - On valid & k_ready with 1 ≤ hv_length ≤ MAX: latch, done<=0, off<=0, op<=0, address<=hv_base[0] → S_READ.
    - On valid & k_ready with an illegal length: error<=1 for one cycle, stay in S_IDLE.
  - S_READ: memory latency cycle → S_LATCH.
  - S_LATCH: buff<=data_rd → S_SEND.
  - S_SEND:
    - k_valid=1, k_data_in=buff, k_first=(op==0), k_last=(op==NUM_OPERANDS-1).
    - Hold all outputs while k_ready=0.
    - On k_ready with op<NUM_OPERANDS-1: op++, address<=hv_base[op+1]+off → S_READ.
    - On k_ready otherwise: → S_WAIT.
  - S_WAIT:
    - k_done is sampled only here.
    - On k_done: address<=hvc+off, data_wr<=k_data_out, we_n<=0 → S_WRITE.
  - S_WRITE:
    - we_n<=1.
    - If off==latched length-1: done<=1 → S_IDLE.
    - Else: off++, op<=0, address<=hv_base[0]+off+1 → S_READ.
- Combinational outputs: k_valid, k_first and k_last are combinational from state and op; all are 0 outside S_SEND. k_data_in = buff.
- Address arithmetic: modulo 2^HV_ADDRESS_WIDTH; carries out are discarded, so a base near all-ones wraps to 0.
- Reset mid-operation: immediate return to reset values. No further write, no kernel beat.

## Timing
- One beat: exactly one transfer per k_valid&k_ready cycle in S_SEND.
- Per-word cost: 3·NUM_OPERANDS + 2 cycles when k_ready=1 and k_done is high on the first S_WAIT cycle. Each k_ready-low cycle or k_done-low cycle adds one.
- Total latency: done rises len·(3·NUM_OPERANDS+2) cycles after the accepting edge.
- Writes: exactly one per word, we_n low for one cycle, with address and data_wr stable in that cycle.
- Request during busy: no effect, no error pulse.

## Structure
- Shared package bind_stream_mapper_pkg holds:
  - typedef enum BindStream_State_t {S_IDLE, S_READ, S_LATCH, S_SEND, S_WAIT, S_WRITE}
  - localparam LW
- No sub-module: a single FSM with inline op/off counters and a base-address mux.

## Test plan
- NUM_OPERANDS=2, len=1, bases 0x10/0x20, hvc=0x30, mem[0x10]=0xA5, mem[0x20]=0x0F, kernel=XOR:
  - Beats 0xA5 (first) then 0x0F (last).
  - mem[0x30]=0xAA.
  - done rises 8 cycles after accept.
- NUM_OPERANDS=3, len=4, contiguous vectors:
  - 12 beats, 4 writes to hvc+0..3 in order.
  - done after 44 cycles.
- k_ready low 5 cycles during the second beat: k_valid and k_data_in held, beat count unchanged, total +5 cycles.
- hv_length=0, and separately hv_length=5 with MAX=4: one-cycle error pulse, no memory access, done stays 1.
- hv_base[0]=0xFFFFF, len=2: second read at 0x00000.
- reset_n low during S_WAIT of word 1: outputs return to reset values, no write to hvc+1, a new request then runs normally.

Source files
------------

// File: rtl/bind_stream_mapper_pkg.sv
// rtl/bind_stream_mapper_pkg.sv - shared types and constants for the bind stream mapper
//
// Purpose: FSM state encoding and the default hypervector length width used by
// the mapper and by anything that drives its hv_length port.
// Ports:   none (package).

package bind_stream_mapper_pkg;

  localparam int DEFAULT_MAX_HV_LENGTH = 4;

  // Width of a length field able to hold 0..DEFAULT_MAX_HV_LENGTH inclusive.
  localparam int LW = $clog2(DEFAULT_MAX_HV_LENGTH + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_LATCH = 3'd2,
    S_SEND  = 3'd3,
    S_WAIT  = 3'd4,
    S_WRITE = 3'd5
  } BindStream_State_t;

endpackage

// File: rtl/bind_stream_mapper.sv
// rtl/bind_stream_mapper.sv - memory-side operand streamer / result writer for bind kernels
//
// Purpose: for every word offset of a hypervector, reads NUM_OPERANDS operand
// words from single-port memory, streams them to the kernel as one first/last
// framed burst, waits for the kernel result and writes it to the destination.
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   valid, hv_base, hvc,      request from the kernel mapper (operand bases,
//   hv_length                 destination base, words to process)
//   done, error               idle/complete flag, one-cycle reject pulse
//   we_n, address, data_wr,   registered memory port (write enable active-low);
//   data_rd                   read data valid the cycle after address changes
//   k_valid, k_first, k_last, kernel beat stream (combinational from state/op)
//   k_data_in, k_ready
//   k_data_out, k_done        kernel result and result-valid

module bind_stream_mapper
  import bind_stream_mapper_pkg::*;
#(
  parameter int HV_DATA_WIDTH          = 32,
  parameter int HV_ADDRESS_WIDTH       = 20,
  parameter int MAX_HYPERVECTOR_LENGTH = DEFAULT_MAX_HV_LENGTH,
  parameter int NUM_OPERANDS           = 2,
  localparam int LEN_W                 = $clog2(MAX_HYPERVECTOR_LENGTH + 1)
) (
  input  logic                                     clk,
  input  logic                                     reset_n,
  input  logic                                     valid,
  input  logic [NUM_OPERANDS*HV_ADDRESS_WIDTH-1:0] hv_base,
  input  logic [HV_ADDRESS_WIDTH-1:0]              hvc,
  input  logic [LEN_W-1:0]                         hv_length,
  output logic                                     done,
  output logic                                     error,
  output logic                                     we_n,
  output logic [HV_ADDRESS_WIDTH-1:0]              address,
  output logic [HV_DATA_WIDTH-1:0]                 data_wr,
  input  logic [HV_DATA_WIDTH-1:0]                 data_rd,
  output logic                                     k_valid,
  output logic                                     k_first,
  output logic                                     k_last,
  output logic [HV_DATA_WIDTH-1:0]                 k_data_in,
  input  logic [HV_DATA_WIDTH-1:0]                 k_data_out,
  input  logic                                     k_ready,
  input  logic                                     k_done
);

  localparam int AW  = HV_ADDRESS_WIDTH;
  localparam int OPW = (NUM_OPERANDS > 1) ? $clog2(NUM_OPERANDS) : 1;
  localparam logic [OPW-1:0]   OP_LAST = OPW'(NUM_OPERANDS - 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_HYPERVECTOR_LENGTH);

  BindStream_State_t                 state;
  logic [NUM_OPERANDS-1:0][AW-1:0]   bases;
  logic [AW-1:0]                     hvc_q;
  logic [LEN_W-1:0]                  len_q;
  logic [LEN_W-1:0]                  off;
  logic [OPW-1:0]                    op;
  logic [OPW-1:0]                    op_next;
  logic [AW-1:0]                     off_ext;
  logic [HV_DATA_WIDTH-1:0]          buff;
  logic                              len_ok;

  assign len_ok  = (hv_length != '0) && (hv_length <= LEN_MAX);
  assign op_next = op + 1'b1;
  assign off_ext = AW'(off);

  // Registered datapath and FSM. Address sums deliberately drop the carry so
  // a base near all-ones wraps around to the bottom of memory.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      done    <= 1'b1;
      error   <= 1'b0;
      we_n    <= 1'b1;
      address <= '1;
      data_wr <= '0;
      buff    <= '0;
      off     <= '0;
      op      <= '0;
      bases   <= '0;
      hvc_q   <= '0;
      len_q   <= '0;
    end else begin
      error <= 1'b0;
      case (state)
        S_IDLE: begin
          done <= 1'b1;
          we_n <= 1'b1;
          if (valid && k_ready) begin
            if (len_ok) begin
              bases   <= hv_base;
              hvc_q   <= hvc;
              len_q   <= hv_length;
              done    <= 1'b0;
              off     <= '0;
              op      <= '0;
              address <= hv_base[AW-1:0];
              state   <= S_READ;
            end else begin
              error <= 1'b1;
            end
          end
        end
        S_READ:  state <= S_LATCH;
        S_LATCH: begin
          buff  <= data_rd;
          state <= S_SEND;
        end
        S_SEND: begin
          if (k_ready) begin
            if (op != OP_LAST) begin
              op      <= op_next;
              address <= bases[op_next] + off_ext;
              state   <= S_READ;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (k_done) begin
            address <= hvc_q + off_ext;
            data_wr <= k_data_out;
            we_n    <= 1'b0;
            state   <= S_WRITE;
          end
        end
        S_WRITE: begin
          we_n <= 1'b1;
          if (off == len_q - 1'b1) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end else begin
            off     <= off + 1'b1;
            op      <= '0;
            address <= bases[0] + off_ext + 1'b1;
            state   <= S_READ;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Beat framing is purely a function of state and operand index, so a
  // stalled beat keeps the same valid/first/last/data until accepted.
  assign k_valid   = (state == S_SEND);
  assign k_first   = k_valid && (op == '0);
  assign k_last    = k_valid && (op == OP_LAST);
  assign k_data_in = buff;

endmodule

// File: tb/tb_bind_stream_mapper.sv
// tb/tb_bind_stream_mapper.sv - directed self-checking bench for bind_stream_mapper

module tb_bind_stream_mapper;
  import bind_stream_mapper_pkg::*;

  localparam int AW = 20;
  localparam int DW = 32;

  logic            clk;
  logic            reset_n;
  logic            valid_a, valid_b;
  logic [2*AW-1:0] hv_base_a;
  logic [3*AW-1:0] hv_base_b;
  logic [AW-1:0]   hvc;
  logic [LW-1:0]   hv_length;
  logic            k_ready_base, stall_active, stall_req, k_ready;
  logic            k_done_en;

  logic            done_a, error_a, we_n_a, k_valid_a, k_first_a, k_last_a, k_done_a;
  logic [AW-1:0]   address_a;
  logic [DW-1:0]   data_wr_a, data_rd_a, k_data_in_a, k_data_out_a;
  logic            done_b, error_b, we_n_b, k_valid_b, k_first_b, k_last_b, k_done_b;
  logic [AW-1:0]   address_b;
  logic [DW-1:0]   data_wr_b, data_rd_b, k_data_in_b, k_data_out_b;

  assign k_ready = k_ready_base & ~stall_active;

  bind_stream_mapper #(.HV_DATA_WIDTH(DW), .HV_ADDRESS_WIDTH(AW),
                       .MAX_HYPERVECTOR_LENGTH(4), .NUM_OPERANDS(2)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .valid(valid_a), .hv_base(hv_base_a), .hvc(hvc),
    .hv_length(hv_length), .done(done_a), .error(error_a), .we_n(we_n_a),
    .address(address_a), .data_wr(data_wr_a), .data_rd(data_rd_a),
    .k_valid(k_valid_a), .k_first(k_first_a), .k_last(k_last_a),
    .k_data_in(k_data_in_a), .k_data_out(k_data_out_a), .k_ready(k_ready),
    .k_done(k_done_a));

  bind_stream_mapper #(.HV_DATA_WIDTH(DW), .HV_ADDRESS_WIDTH(AW),
                       .MAX_HYPERVECTOR_LENGTH(4), .NUM_OPERANDS(3)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .valid(valid_b), .hv_base(hv_base_b), .hvc(hvc),
    .hv_length(hv_length), .done(done_b), .error(error_b), .we_n(we_n_b),
    .address(address_b), .data_wr(data_wr_b), .data_rd(data_rd_b),
    .k_valid(k_valid_b), .k_first(k_first_b), .k_last(k_last_b),
    .k_data_in(k_data_in_b), .k_data_out(k_data_out_b), .k_ready(k_ready),
    .k_done(k_done_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-only memory images; writes are captured in logs instead.
  logic [DW-1:0] mem_a [256];
  logic [DW-1:0] mem_b [256];
  always @(posedge clk) begin
    data_rd_a <= mem_a[address_a[7:0]];
    data_rd_b <= mem_b[address_b[7:0]];
  end

  // XOR kernel models: result becomes pending after the last beat.
  logic [DW-1:0] acc_a, res_a, acc_b, res_b;
  logic          pend_a, pend_b;
  wire  [DW-1:0] x_a = k_first_a ? k_data_in_a : (acc_a ^ k_data_in_a);
  wire  [DW-1:0] x_b = k_first_b ? k_data_in_b : (acc_b ^ k_data_in_b);
  assign k_done_a     = pend_a & k_done_en;
  assign k_done_b     = pend_b & k_done_en;
  assign k_data_out_a = res_a;
  assign k_data_out_b = res_b;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_a <= '0; res_a <= '0; pend_a <= 1'b0;
      acc_b <= '0; res_b <= '0; pend_b <= 1'b0;
    end else begin
      if (k_done_a) pend_a <= 1'b0;
      if (k_done_b) pend_b <= 1'b0;
      if (k_valid_a && k_ready) begin
        acc_a <= x_a;
        if (k_last_a) begin res_a <= x_a; pend_a <= 1'b1; end
      end
      if (k_valid_b && k_ready) begin
        acc_b <= x_b;
        if (k_last_b) begin res_b <= x_b; pend_b <= 1'b1; end
      end
    end
  end

  // Activity logs.
  int            beat_cnt_a = 0, wr_cnt_a = 0, adr_cnt_a = 0, err_cnt_a = 0;
  int            beat_cnt_b = 0, wr_cnt_b = 0;
  logic [DW-1:0] beat_d_a [64];
  logic          beat_f_a [64];
  logic          beat_l_a [64];
  logic [AW-1:0] wr_addr_a [16];
  logic [DW-1:0] wr_data_a [16];
  logic [AW-1:0] wr_addr_b [16];
  logic [DW-1:0] wr_data_b [16];
  logic [AW-1:0] adr_log_a [64];
  logic [AW-1:0] adr_prev_a = '1;

  always @(posedge clk) begin
    if (k_valid_a && k_ready) begin
      beat_d_a[beat_cnt_a % 64] <= k_data_in_a;
      beat_f_a[beat_cnt_a % 64] <= k_first_a;
      beat_l_a[beat_cnt_a % 64] <= k_last_a;
      beat_cnt_a <= beat_cnt_a + 1;
    end
    if (!we_n_a) begin
      wr_addr_a[wr_cnt_a % 16] <= address_a;
      wr_data_a[wr_cnt_a % 16] <= data_wr_a;
      wr_cnt_a <= wr_cnt_a + 1;
    end
    if (address_a != adr_prev_a) begin
      adr_log_a[adr_cnt_a % 64] <= address_a;
      adr_cnt_a  <= adr_cnt_a + 1;
      adr_prev_a <= address_a;
    end
    if (error_a) err_cnt_a <= err_cnt_a + 1;
    if (k_valid_b && k_ready) beat_cnt_b <= beat_cnt_b + 1;
    if (!we_n_b) begin
      wr_addr_b[wr_cnt_b % 16] <= address_b;
      wr_data_b[wr_cnt_b % 16] <= data_wr_b;
      wr_cnt_b <= wr_cnt_b + 1;
    end
  end

  // Stall injector: holds k_ready low for five cycles when the second beat of
  // a frame on instance a first appears, recording whether the beat is held.
  logic hold_ok, stall_seen;
  int   stall_beat_delta;
  initial begin
    int sb0;
    stall_active     = 1'b0;
    hold_ok          = 1'b1;
    stall_seen       = 1'b0;
    stall_beat_delta = 0;
    forever begin
      @(negedge clk);
      if (stall_req && k_valid_a && !k_first_a) begin
        stall_active = 1'b1;
        sb0 = beat_cnt_a;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          if (!(k_valid_a && k_last_a && (k_data_in_a == 32'h0000_000F))) hold_ok = 1'b0;
        end
        stall_beat_delta = beat_cnt_a - sb0;
        stall_active = 1'b0;
        stall_seen   = 1'b1;
        while (stall_req) @(negedge clk);
      end
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Issues one request and counts cycles from the accepting edge to done.
  // With poke set, a conflicting illegal request is held during the busy phase.
  task automatic run_req(input bit sel, input bit poke, input logic [2*AW-1:0] ba,
                         input logic [3*AW-1:0] bb, input logic [AW-1:0] h,
                         input logic [LW-1:0] len, output int cycles);
    @(negedge clk);
    hv_base_a = ba; hv_base_b = bb; hvc = h; hv_length = len;
    if (sel) valid_b = 1'b1; else valid_a = 1'b1;
    @(posedge clk); #1;
    valid_a = 1'b0; valid_b = 1'b0;
    check_eq(sel ? "busy_b" : "busy_a", sel ? done_b : done_a, 0);
    cycles = 0;
    while (cycles < 400) begin
      @(posedge clk); #1;
      cycles++;
      if ((sel ? done_b : done_a) == 1'b1) break;
      if (poke && cycles == 2) begin
        hv_base_a = '1; hvc = 20'h000EE; hv_length = '0; valid_a = 1'b1;
      end
    end
    valid_a = 1'b0; valid_b = 1'b0;
  endtask

  initial begin
    int cyc, bc, wc, ac, ec, n;
    logic [AW-1:0] ad;
    logic [LW-1:0] bad_len [2];
    logic [AW-1:0] wrap_seq [6];
    logic [DW-1:0] exp_w;

    bad_len[0] = 3'd0;
    bad_len[1] = 3'd5;
    wrap_seq[0] = 20'hFFFFF; wrap_seq[1] = 20'h00020; wrap_seq[2] = 20'h00080;
    wrap_seq[3] = 20'h00000; wrap_seq[4] = 20'h00021; wrap_seq[5] = 20'h00081;

    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 32'hDEAD_0000 | i;
      mem_b[i] = (i * 32'h0101_0107) ^ 32'h5A5A_0000;
    end
    mem_a[8'h10] = 32'h0000_00A5; mem_a[8'h20] = 32'h0000_000F;
    mem_a[8'hFF] = 32'h0000_0011; mem_a[8'h00] = 32'h0000_0022;
    mem_a[8'h21] = 32'h0000_0033;

    reset_n = 1'b0; valid_a = 1'b0; valid_b = 1'b0; hv_base_a = '0; hv_base_b = '0;
    hvc = '0; hv_length = '0; k_ready_base = 1'b1; k_done_en = 1'b1; stall_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_done",    done_a, 1);
    check_eq("rst_error",   error_a, 0);
    check_eq("rst_we_n",    we_n_a, 1);
    check_eq("rst_address", address_a, 20'hFFFFF);
    check_eq("rst_data_wr", data_wr_a, 0);
    check_eq("rst_k_valid", {k_valid_a, k_first_a, k_last_a}, 0);
    check_eq("rst_k_data",  k_data_in_a, 0);
    check_eq("rst_done_b",  done_b, 1);
    @(negedge clk); reset_n = 1'b1;

    // Two operands, one word, XOR kernel.
    bc = beat_cnt_a; wc = wr_cnt_a;
    run_req(0, 0, {20'h00020, 20'h00010}, '0, 20'h00030, 3'd1, cyc);
    check_eq("n2_cycles", cyc, 8);
    check_eq("n2_beats", beat_cnt_a - bc, 2);
    check_eq("n2_beat0", {beat_f_a[bc % 64], beat_l_a[bc % 64], beat_d_a[bc % 64]}, {2'b10, 32'hA5});
    check_eq("n2_beat1", {beat_f_a[(bc+1) % 64], beat_l_a[(bc+1) % 64], beat_d_a[(bc+1) % 64]}, {2'b01, 32'h0F});
    check_eq("n2_writes", wr_cnt_a - wc, 1);
    check_eq("n2_wr_addr", wr_addr_a[wc % 16], 20'h00030);
    check_eq("n2_wr_data", wr_data_a[wc % 16], 32'hAA);

    // Five-cycle k_ready stall during the second beat.
    bc = beat_cnt_a; wc = wr_cnt_a;
    stall_req = 1'b1;
    run_req(0, 0, {20'h00020, 20'h00010}, '0, 20'h00030, 3'd1, cyc);
    stall_req = 1'b0;
    check_eq("stall_seen", stall_seen, 1);
    check_eq("stall_hold", hold_ok, 1);
    check_eq("stall_no_beat", stall_beat_delta, 0);
    check_eq("stall_cycles", cyc, 13);
    check_eq("stall_beats", beat_cnt_a - bc, 2);
    check_eq("stall_wr_data", wr_data_a[wc % 16], 32'hAA);

    // Illegal lengths are rejected with a single error pulse.
    for (int t = 0; t < 2; t++) begin
      wc = wr_cnt_a; ac = adr_cnt_a; ad = address_a;
      @(negedge clk);
      hv_length = bad_len[t]; hvc = 20'h00055; valid_a = 1'b1;
      @(posedge clk); #1;
      check_eq("err_pulse", error_a, 1);
      check_eq("err_done", done_a, 1);
      @(negedge clk); valid_a = 1'b0;
      @(posedge clk); #1;
      check_eq("err_one_cycle", error_a, 0);
      check_eq("err_done2", done_a, 1);
      check_eq("err_address", address_a, ad);
      check_eq("err_no_access", (wr_cnt_a - wc) + (adr_cnt_a - ac), 0);
    end

    // Address wrap from an all-ones base, with a conflicting request while busy.
    wc = wr_cnt_a; ac = adr_cnt_a; ec = err_cnt_a;
    run_req(0, 1, {20'h00020, 20'hFFFFF}, '0, 20'h00080, 3'd2, cyc);
    check_eq("wrap_cycles", cyc, 16);
    check_eq("wrap_writes", wr_cnt_a - wc, 2);
    check_eq("wrap_wr0", {wr_addr_a[wc % 16], wr_data_a[wc % 16]}, {20'h00080, 32'h1E});
    check_eq("wrap_wr1", {wr_addr_a[(wc+1) % 16], wr_data_a[(wc+1) % 16]}, {20'h00081, 32'h11});
    for (int i = 0; i < 6; i++)
      check_eq($sformatf("wrap_addr%0d", i), adr_log_a[(ac + i) % 64], wrap_seq[i]);
    check_eq("busy_no_error", err_cnt_a - ec, 0);

    // Three operands, four contiguous words.
    bc = beat_cnt_b; wc = wr_cnt_b;
    run_req(1, 0, '0, {20'h00060, 20'h00050, 20'h00040}, 20'h00070, 3'd4, cyc);
    check_eq("n3_cycles", cyc, 44);
    check_eq("n3_beats", beat_cnt_b - bc, 12);
    check_eq("n3_writes", wr_cnt_b - wc, 4);
    for (int w = 0; w < 4; w++) begin
      exp_w = mem_b[8'h40 + w] ^ mem_b[8'h50 + w] ^ mem_b[8'h60 + w];
      check_eq($sformatf("n3_wr%0d", w), {wr_addr_b[(wc+w) % 16], wr_data_b[(wc+w) % 16]},
               {AW'(20'h00070 + w), exp_w});
    end

    // Reset while waiting for the kernel result of word 1.
    bc = beat_cnt_a; wc = wr_cnt_a;
    @(negedge clk);
    hv_base_a = {20'h00021, 20'h00011}; hvc = 20'h00090; hv_length = 3'd2; valid_a = 1'b1;
    @(posedge clk); #1;
    valid_a = 1'b0;
    n = 0;
    while (wr_cnt_a == wc && n < 200) begin @(posedge clk); #1; n++; end
    k_done_en = 1'b0;
    check_eq("rstw_word0", wr_cnt_a - wc, 1);
    n = 0;
    while ((beat_cnt_a - bc) < 4 && n < 200) begin @(posedge clk); #1; n++; end
    repeat (3) @(posedge clk);
    #1;
    check_eq("rstw_waiting", {done_a, we_n_a, k_valid_a}, 3'b010);
    @(negedge clk); reset_n = 1'b0;
    #1;
    check_eq("rstw_done",    done_a, 1);
    check_eq("rstw_we_n",    we_n_a, 1);
    check_eq("rstw_address", address_a, 20'hFFFFF);
    check_eq("rstw_data_wr", data_wr_a, 0);
    check_eq("rstw_k",       {k_valid_a, k_first_a, k_last_a, k_data_in_a}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset_n = 1'b1; k_done_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rstw_no_write", wr_cnt_a - wc, 1);
    check_eq("rstw_no_beat", beat_cnt_a - bc, 4);
    wc = wr_cnt_a;
    run_req(0, 0, {20'h00020, 20'h00010}, '0, 20'h00030, 3'd1, cyc);
    check_eq("rstw_rerun_cycles", cyc, 8);
    check_eq("rstw_rerun_wr", {wr_addr_a[wc % 16], wr_data_a[wc % 16]}, {20'h00030, 32'hAA});
    check_eq("rstw_rerun_writes", wr_cnt_a - wc, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
